// File: rtl/sd_pkg.sv
// Shared definitions for the signed-digit word converter: FSM states, carry encoding
// and the plus/minus rail decoder.
package sd_pkg;

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   localparam logic [1:0] CARRY_POS = 2'b10;
   localparam logic [1:0] CARRY_NEG = 2'b01;

   // Widest digit group the rail decoder handles; callers zero-extend narrower rails.
   localparam int unsigned MAX_BITS = 16;

   function automatic logic signed [MAX_BITS:0] sd_group_value(
      input logic [MAX_BITS-1:0] plus,
      input logic [MAX_BITS-1:0] minus
   );
      return $signed({1'b0, plus}) - $signed({1'b0, minus});
   endfunction

   function automatic logic signed [1:0] sd_carry_value(input logic [1:0] carry);
      case (carry)
         CARRY_POS: return 2'sb01;
         CARRY_NEG: return 2'sb11;
         default:   return 2'sb00;
      endcase
   endfunction

endpackage

// File: rtl/sd_word_converter_if.sv
// Digit-group input stream and converted-word output stream of sd_word_converter.
interface sd_word_converter_if #(
   parameter int unsigned bits   = 4,
   parameter int unsigned groups = 4,
   parameter int unsigned W      = bits * groups + 2
);
   logic            in_valid;
   logic            in_ready;
   logic [bits-1:0] in_plus;
   logic [bits-1:0] in_minus;
   logic [1:0]      in_carry;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    out_data;

   modport master (
      output in_valid, in_plus, in_minus, in_carry, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_plus, in_minus, in_carry, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/sd_otf_step.sv
// One on-the-fly conversion step: appends a radix-2^bits digit v to the Q/QM pair,
// where QM always tracks Q - 1.
module sd_otf_step #(
   parameter int unsigned bits = 4,
   parameter int unsigned W    = 18
) (
   input  logic signed [W-1:0] q,
   input  logic signed [W-1:0] qm,
   input  logic signed [W-1:0] v,
   output logic signed [W-1:0] q_nxt,
   output logic signed [W-1:0] qm_nxt
);

   localparam logic signed [W-1:0] Radix = W'(1) << bits;
   localparam logic signed [W-1:0] One   = W'(1);

   logic signed [W-1:0] q_sh;
   logic signed [W-1:0] qm_sh;

   always_comb begin
      q_sh  = q <<< bits;
      qm_sh = qm <<< bits;

      // Negative digits borrow from QM instead of propagating a carry through Q.
      if (v >= 0) q_nxt = q_sh + v;
      else        q_nxt = qm_sh + Radix + v;

      if (v > 0) qm_nxt = q_sh + v - One;
      else       qm_nxt = qm_sh + Radix - One + v;
   end

endmodule

// File: rtl/sd_word_converter.sv
// Assembles MSB-first signed-digit groups into a two's-complement word using Q/QM
// on-the-fly conversion, then holds it on a valid/ready output.
module sd_word_converter
   import sd_pkg::*;
#(
   parameter int unsigned bits   = 4,
   parameter int unsigned groups = 4,
   parameter int unsigned W      = bits * groups + 2
) (
   input logic               clk,
   input logic               rst,
   sd_word_converter_if.slave bus
);

   localparam int unsigned CntW = $clog2(groups + 1);

   state_e              state_q, state_d;
   logic signed [W-1:0] q_q, q_d, qm_q, qm_d;
   logic [CntW-1:0]     cnt_q, cnt_d;

   logic                    accept;
   logic signed [MAX_BITS:0] v_raw;
   logic signed [W-1:0]     v, c;
   logic signed [W-1:0]     base_q, base_qm, step_q, step_qm;

   assign accept = bus.in_valid && bus.in_ready;
   assign v_raw  = sd_group_value(MAX_BITS'(bus.in_plus), MAX_BITS'(bus.in_minus));
   assign v      = W'(v_raw);
   assign c      = W'(sd_carry_value(bus.in_carry));

   // The first group of a word seeds Q/QM from the adder's carry.
   assign base_q  = (state_q == StIdle) ? c : q_q;
   assign base_qm = (state_q == StIdle) ? c - W'(1) : qm_q;

   sd_otf_step #(
      .bits (bits),
      .W    (W)
   ) u_step (
      .q      (base_q),
      .qm     (base_qm),
      .v      (v),
      .q_nxt  (step_q),
      .qm_nxt (step_qm)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         q_q     <= '0;
         qm_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         qm_q    <= qm_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = (groups == 1) ? StDone : StAccum;
         StAccum: if (accept && cnt_q == CntW'(groups - 1)) state_d = StDone;
         StDone:  if (bus.out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      q_d   = q_q;
      qm_d  = qm_q;
      cnt_d = cnt_q;
      if (accept) begin
         q_d   = step_q;
         qm_d  = step_qm;
         cnt_d = (state_q == StIdle) ? CntW'(1) : cnt_q + CntW'(1);
      end
      if (state_q == StDone && bus.out_ready) cnt_d = '0;
   end

   always_comb begin
      bus.in_ready  = (state_q != StDone);
      bus.out_valid = (state_q == StDone);
      bus.out_data  = q_q;
   end

endmodule
